// File: rtl/xor_seq_pkg.sv
// Shared types for the chunked XOR sequencer.
// FSM state encoding and opcode constants.
package xor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic OP_XOR  = 1'b0;
  localparam logic OP_FOLD = 1'b1;

endpackage

// File: rtl/xor_chunk_seq_cell.sv
// Gate-level W-bit XOR cell.
// Shared by every chunk step of the sequencer.
module xor_chunk_seq_cell #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] z_o
);

  for (genvar g = 0; g < W; g++) begin : g_bit
    xor u_xor (z_o[g], x_i[g], y_i[g]);
  end

endmodule

// File: rtl/xor_chunk_seq.sv
// Multi-cycle sequencer around one shared XOR cell.
// Chunk-wise XOR of two operands, or XOR-fold of one.
module xor_chunk_seq
  import xor_seq_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic [W*N-1:0] a,
  input  logic [W*N-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*N-1:0] out_data,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W*N-1:0] a_q, a_d;
  logic [W*N-1:0] b_q, b_d;
  logic           op_q, op_d;
  logic [W*N-1:0] out_q, out_d;

  logic [W-1:0]   a_ch, b_ch;
  logic [W-1:0]   cell_x, cell_y, cell_z;
  logic           last;
  logic           fold;

  assign last = (idx_q == IW'(N - 1));
  assign fold = (op_q == OP_FOLD);

  // Select the current chunk of each latched operand.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        a_ch = a_q[i*W +: W];
        b_ch = b_q[i*W +: W];
      end
    end
  end

  assign cell_x = fold ? acc_q : a_ch;
  assign cell_y = fold ? a_ch  : b_ch;

  xor_chunk_seq_cell #(
    .W (W)
  ) u_cell (
    .x_i (cell_x),
    .y_i (cell_y),
    .z_o (cell_z)
  );

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come from registered state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Datapath next-state: load on accept, one chunk per RUN cycle.
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    out_d = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          op_d  = op;
          idx_d = '0;
          acc_d = '0;
          out_d = '0;
        end
      end
      RUN: begin
        if (fold) begin
          acc_d = cell_z;
          if (last) begin
            out_d          = '0;
            out_d[W-1:0]   = cell_z;
          end
        end else begin
          for (int i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) out_d[i*W +: W] = cell_z;
          end
        end
        idx_d = last ? '0 : idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_XOR;
      out_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      out_q <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_xor_chunk_seq.sv
// Directed bench for xor_chunk_seq.
// Covers N=4 and N=1 builds.
module tb_xor_chunk_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op;
  logic [31:0] a, b, out_data;
  logic        out_valid, out_ready, busy;

  logic        in_valid1, in_ready1, op1;
  logic [7:0]  a1, b1, out_data1;
  logic        out_valid1, out_ready1, busy1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  xor_chunk_seq #(.W(8), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  xor_chunk_seq #(.W(8), .N(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .op        (op1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .busy      (busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op and wait (bounded) for out_valid.
  task automatic run_op(input logic o, input logic [31:0] av,
                        input logic [31:0] bv, output int lat);
    in_valid = 1'b1;
    op = o;
    a = av;
    b = bv;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    vecs++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out_data !== 32'h0) begin
      errs++;
      $display("FAIL reset: ov/busy/rdy=%b data=%h want 001 00000000",
               {out_valid, busy, in_ready}, out_data);
    end
    vecs++;
    if ({out_valid1, busy1, in_ready1} !== 3'b001 || out_data1 !== 8'h0) begin
      errs++;
      $display("FAIL reset_n1: ov/busy/rdy=%b data=%h want 001 00",
               {out_valid1, busy1, in_ready1}, out_data1);
    end
  endtask

  task automatic test_xor();
    int lat;
    in_valid = 1'b1;
    op = 1'b0;
    a = 32'h12345678;
    b = 32'hFFFF0000;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      vecs++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL xor_run_busy: busy=%b rdy=%b want 1 0",
                 busy, in_ready);
      end
      tick();
      lat++;
    end
    vecs++;
    if (lat !== 4) begin
      errs++;
      $display("FAIL xor_latency: got %0d want 4", lat);
    end
    vecs++;
    if (out_data !== 32'hEDCB5678 || busy !== 1'b1) begin
      errs++;
      $display("FAIL xor_data: got %h busy=%b want EDCB5678 1",
               out_data, busy);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vecs++;
    if ({out_valid, busy, in_ready} !== 3'b001 ||
        out_data !== 32'hEDCB5678) begin
      errs++;
      $display("FAIL xor_release: flags=%b data=%h want 001 EDCB5678",
               {out_valid, busy, in_ready}, out_data);
    end
  endtask

  task automatic test_fold();
    int lat;
    run_op(1'b1, 32'h12345678, 32'hDEADBEEF, lat);
    vecs++;
    if (lat !== 4 || out_data !== 32'h00000008) begin
      errs++;
      $display("FAIL fold: lat=%0d data=%h want 4 00000008",
               lat, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(1'b0, 32'h0F0F0F0F, 32'h01020304, lat);
    vecs++;
    if (lat !== 4) begin
      errs++;
      $display("FAIL bp_latency: got %0d want 4", lat);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        in_valid = 1'b1;
        op = 1'b1;
        a = 32'hFFFFFFFF;
        b = 32'h0;
      end
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_data !== 32'h0E0D0C0B) begin
        errs++;
        $display("FAIL bp_hold[%0d]: ov=%b rdy=%b data=%h want 1 0 0E0D0C0B",
                 k, out_valid, in_ready, out_data);
      end
      tick();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vecs++;
    if ({out_valid, busy, in_ready} !== 3'b001 ||
        out_data !== 32'h0E0D0C0B) begin
      errs++;
      $display("FAIL bp_release: flags=%b data=%h want 001 0E0D0C0B",
               {out_valid, busy, in_ready}, out_data);
    end
    tick();
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL bp_ignored: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_midrun();
    int lat;
    in_valid = 1'b1;
    op = 1'b0;
    a = 32'h11223344;
    b = 32'h0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out_data !== 32'h0) begin
      errs++;
      $display("FAIL midrun_reset: flags=%b data=%h want 001 00000000",
               {out_valid, busy, in_ready}, out_data);
    end
    run_op(1'b0, 32'hFFFFFFFF, 32'h0F0F0F0F, lat);
    vecs++;
    if (lat !== 4 || out_data !== 32'hF0F0F0F0) begin
      errs++;
      $display("FAIL after_reset_xor: lat=%0d data=%h want 4 F0F0F0F0",
               lat, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_n1();
    in_valid1 = 1'b1;
    op1 = 1'b0;
    a1 = 8'hA5;
    b1 = 8'h5A;
    tick();
    in_valid1 = 1'b0;
    vecs++;
    if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin
      errs++;
      $display("FAIL n1_run: ov=%b busy=%b want 0 1", out_valid1, busy1);
    end
    tick();
    vecs++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'hFF) begin
      errs++;
      $display("FAIL n1_xor: ov=%b data=%h want 1 FF",
               out_valid1, out_data1);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    in_valid1 = 1'b1;
    op1 = 1'b1;
    a1 = 8'hA5;
    b1 = 8'h33;
    tick();
    in_valid1 = 1'b0;
    tick();
    vecs++;
    if (out_valid1 !== 1'b1 || out_data1 !== 8'hA5) begin
      errs++;
      $display("FAIL n1_fold: ov=%b data=%h want 1 A5",
               out_valid1, out_data1);
    end
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic        vop [4];
    logic [31:0] va  [4];
    logic [31:0] vb  [4];
    logic [31:0] vexp[4];
    int acc_n, res_n, cyc, last_acc;
    vop[0] = 1'b0; va[0] = 32'hA5A5A5A5; vb[0] = 32'h0000FFFF;
    vexp[0] = 32'hA5A55A5A;
    vop[1] = 1'b1; va[1] = 32'h01020408; vb[1] = 32'h77777777;
    vexp[1] = 32'h0000000F;
    vop[2] = 1'b0; va[2] = 32'hCAFEBABE; vb[2] = 32'h12345678;
    vexp[2] = 32'hD8CAECC6;
    vop[3] = 1'b1; va[3] = 32'hFF00FF01; vb[3] = 32'h12345678;
    vexp[3] = 32'h00000001;
    acc_n = 0;
    res_n = 0;
    last_acc = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = vop[0];
    a = va[0];
    b = vb[0];
    while (res_n < 4 && cyc < 60) begin
      if (out_valid && out_ready) begin
        vecs++;
        if (out_data !== vexp[res_n]) begin
          errs++;
          $display("FAIL stream_data[%0d]: got %h want %h",
                   res_n, out_data, vexp[res_n]);
        end
        res_n++;
      end
      if (in_valid && in_ready) begin
        if (acc_n > 0) begin
          vecs++;
          if (cyc - last_acc !== 6) begin
            errs++;
            $display("FAIL stream_gap[%0d]: got %0d want 6",
                     acc_n, cyc - last_acc);
          end
        end
        last_acc = cyc;
        acc_n++;
      end
      tick();
      cyc++;
      if (acc_n < 4) begin
        op = vop[acc_n];
        a = va[acc_n];
        b = vb[acc_n];
      end else begin
        in_valid = 1'b0;
      end
    end
    vecs++;
    if (res_n !== 4) begin
      errs++;
      $display("FAIL stream_timeout: results=%0d want 4", res_n);
    end
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    in_valid1 = 1'b0;
    op1 = 1'b0;
    a1 = '0;
    b1 = '0;
    out_ready1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_xor();
    test_fold();
    test_backpressure();
    test_reset_midrun();
    test_n1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
